tnn_feature_sequencer: RTL and testbench
========================================

# tnn_feature_sequencer

Streaming front end for the 2-bit-per-feature approximate TNN classifier cores. It accepts raw feature samples one per beat over valid/ready and quantizes each one to 2 bits against per-feature thresholds. It assembles the 7-feature input vector, holds it stable for one evaluation cycle of the combinational core, and returns the registered 1-bit class over a valid/ready result channel with a frame-error flag. It sits between the dataset/DMA stream and any CGP classifier netlist of the family.

## Interface
- FEAT_N, 7, features per frame (vector width FEAT_N*Q_W)
- RAW_W, 8, raw sample width
- Q_W, 2, quantized feature width (fixed; thresholds assume 3 levels)
- THRESH, {FEAT_N{8'd192,8'd128,8'd64}}, packed ascending thresholds t0<t1<t2 per feature, feature 0 in LSBs
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  raw sample valid
- s_ready  out  1  sequencer can accept sample
- s_data  in  RAW_W  raw feature value, unsigned
- s_last  in  1  marks final sample of a frame
- cls_vec  out  FEAT_N*Q_W  vector to core; feature k at bits [2k+1:2k] (feature 0 = core port a, 6 = g)
- cls_bit  in  1  combinational core result
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  1  registered class
- m_err  out  1  frame length error for this result

## Operation
- Quantize: q = 3 if x>=t2, 2 if x>=t1, 1 if x>=t0, else 0; unsigned compare, thresholds inclusive.
- FSM states: COLLECT, DRAIN, EVAL, HOLD. Reset state COLLECT.
- COLLECT: s_ready=1. On handshake, write q into slot idx, idx++.
  - s_last with idx==FEAT_N-1: good frame -> EVAL, idx<=0.
  - s_last with idx<FEAT_N-1: short frame -> HOLD with m_class=0, m_err=1, idx<=0.
  - idx==FEAT_N-1 without s_last: long frame -> DRAIN, idx<=0.
- DRAIN: s_ready=1, discard beats until a handshake with s_last -> HOLD with m_class=0, m_err=1.
- EVAL: s_ready=0; cls_vec stable; at end of cycle m_class<=cls_bit, m_err<=0 -> HOLD.
- HOLD: s_ready=0, m_valid=1; outputs frozen until m_valid&&m_ready -> COLLECT.
- cls_vec changes only on COLLECT handshakes; unwritten slots retain prior frame values (short frames are flagged, never evaluated).
- Reset mid-frame or mid-HOLD: partial frame and pending result dropped, no result emitted.

## Timing
- Reset values: s_ready=0 during reset, 1 in the first cycle after deassert; m_valid=0, m_class=0, m_err=0, cls_vec=0, idx=0.
- Latency: last sample handshake in cycle N -> EVAL in N+1 -> m_valid=1 in N+2.
- Error result: m_valid=1 in the cycle after the terminating s_last handshake.
- s_ready=1 in the cycle after the result handshake; minimum frame period FEAT_N+2 cycles at full rate.
- cls_bit is sampled only in EVAL; the core must settle within one clk period.
- m_valid never drops without m_ready; m_class/m_err stable while m_valid=1.
- s_ready is a function of state only (no combinational path from m_ready).

## Structure
- tnn_pkg: FEAT_N, Q_W, state enum type, threshold-unpack helper function.
- Sub-module tnn_feat_quant: one RAW_W->Q_W comparator stage. The sequencer uses one shared instance, with thresholds muxed by idx.
- Core is external; a bench binds any cgp netlist to cls_vec/cls_bit.

## Test plan
- Good frame, default thresholds, samples 0,64,127,128,191,192,255 with s_last on the 7th -> cls_vec=14'b11_11_10_10_01_01_00; m_valid 2 cycles after last beat; m_class equals golden core on that vector; m_err=0.
- Backpressure: hold m_ready=0 for 5 cycles -> m_valid stays 1, outputs stable, s_ready=0; on release, s_ready=1 the next cycle.
- Short frame: s_last on 3rd sample -> m_valid=1 the next cycle, m_class=0, m_err=1; following good frame evaluates correctly.
- Long frame: 10 samples, s_last on 10th -> beats 8-10 accepted and discarded, m_err=1; no EVAL cycle.
- Reset asserted on the 4th sample, then a good frame -> no stale result; the first result matches the new frame only.
- Random gaps in s_valid and random m_ready over 1000 frames -> every result matches the reference model, and no frames are lost or duplicated.

Source files
------------

// File: rtl/tnn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tnn_pkg : shared widths, sequencer state type, threshold unpack helper
// Rev 1.0
// ==========================================================================
package tnn_pkg;

  localparam int FEAT_N = 7;
  localparam int RAW_W  = 8;
  localparam int Q_W    = 2;
  localparam int N_LVL  = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EVAL    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Bit offset of threshold `lvl` of feature `feat` in the packed THRESH vector.
  function automatic int thresh_lsb(input int feat, input int lvl, input int raw_w);
    return (feat * N_LVL + lvl) * raw_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tnn_feat_quant.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tnn_feat_quant : one raw sample -> 2-bit level against ascending thresholds
// Rev 1.0
// ==========================================================================
module tnn_feat_quant #(
  parameter int RAW_W = tnn_pkg::RAW_W,
  parameter int Q_W   = tnn_pkg::Q_W
) (
  input  logic [RAW_W-1:0] x,
  input  logic [RAW_W-1:0] t0,
  input  logic [RAW_W-1:0] t1,
  input  logic [RAW_W-1:0] t2,
  output logic [Q_W-1:0]   q
);

  always_comb begin
    if (x >= t2)      q = Q_W'(3);
    else if (x >= t1) q = Q_W'(2);
    else if (x >= t0) q = Q_W'(1);
    else              q = Q_W'(0);
  end

endmodule
`default_nettype wire

// File: rtl/tnn_feature_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tnn_feature_sequencer : assembles quantized feature frames for the TNN core
// and returns its registered class over valid/ready.  Rev 1.0
// ==========================================================================
module tnn_feature_sequencer #(
  parameter int FEAT_N = tnn_pkg::FEAT_N,
  parameter int RAW_W  = tnn_pkg::RAW_W,
  parameter int Q_W    = tnn_pkg::Q_W,
  parameter logic [FEAT_N*3*RAW_W-1:0] THRESH = {FEAT_N{8'd192, 8'd128, 8'd64}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RAW_W-1:0]      s_data,
  input  logic                  s_last,
  output logic [FEAT_N*Q_W-1:0] cls_vec,
  input  logic                  cls_bit,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_class,
  output logic                  m_err
);

  import tnn_pkg::state_t;
  import tnn_pkg::COLLECT;
  import tnn_pkg::DRAIN;
  import tnn_pkg::EVAL;
  import tnn_pkg::HOLD;
  import tnn_pkg::thresh_lsb;

  localparam int IDX_W = (FEAT_N > 1) ? $clog2(FEAT_N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_N - 1);

  state_t                state;
  state_t                state_nx;
  logic [IDX_W-1:0]      idx;
  logic [FEAT_N*Q_W-1:0] vec;
  logic                  s_ready_r;
  logic                  s_ready_nx;
  logic                  s_hs;
  logic                  at_last;
  logic [Q_W-1:0]        q;
  logic [RAW_W-1:0]      thr [FEAT_N][3];

  for (genvar f = 0; f < FEAT_N; f++) begin : g_feat
    for (genvar l = 0; l < 3; l++) begin : g_lvl
      assign thr[f][l] = THRESH[thresh_lsb(f, l, RAW_W) +: RAW_W];
    end
  end

  tnn_feat_quant #(
    .RAW_W (RAW_W),
    .Q_W   (Q_W)
  ) u_quant (
    .x  (s_data),
    .t0 (thr[idx][0]),
    .t1 (thr[idx][1]),
    .t2 (thr[idx][2]),
    .q  (q)
  );

  assign s_hs    = s_valid && s_ready_r;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      s_ready_r <= 1'b0;
    end else begin
      state     <= state_nx;
      s_ready_r <= s_ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: begin
        if (s_hs) begin
          if (s_last)       state_nx = at_last ? EVAL : HOLD;
          else if (at_last) state_nx = DRAIN;
        end
      end
      DRAIN:   if (s_hs && s_last) state_nx = HOLD;
      EVAL:    state_nx = HOLD;
      HOLD:    if (m_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // s_ready is registered from the next state so it never sees m_ready combinationally.
  always_comb begin
    s_ready_nx = (state_nx == COLLECT) || (state_nx == DRAIN);
    m_valid    = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      vec     <= '0;
      m_class <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (s_hs) begin
            vec[idx*Q_W +: Q_W] <= q;
            idx <= (s_last || at_last) ? '0 : idx + 1'b1;
            if (s_last && !at_last) begin
              m_class <= 1'b0;
              m_err   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (s_hs && s_last) begin
            m_class <= 1'b0;
            m_err   <= 1'b1;
          end
        end
        EVAL: begin
          m_class <= cls_bit;
          m_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_ready = s_ready_r;
  assign cls_vec = vec;

endmodule
`default_nettype wire

// File: tb/tb_tnn_feature_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for tnn_feature_sequencer: directed frames plus 1000 random frames
// against a frame-level reference model with a stand-in golden core.
module tb_tnn_feature_sequencer;

  localparam int FEAT_N = 7;
  localparam int VW     = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [7:0]    s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic          m_class;
  logic          m_err;
  logic          cls_bit;
  logic [VW-1:0] cls_vec;

  int checks  = 0;
  int errors  = 0;
  int results = 0;
  int frames  = 0;
  int model_q [FEAT_N];
  bit early_valid;

  always #5 clk = ~clk;

  tnn_feature_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .cls_vec (cls_vec),
    .cls_bit (cls_bit),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
    .m_err   (m_err)
  );

  // Level = number of thresholds the sample reaches.
  function automatic int quant(input int x);
    int th [3];
    int lv;
    th = '{64, 128, 192};
    lv = 0;
    for (int i = 0; i < 3; i++) if (x >= th[i]) lv++;
    return lv;
  endfunction

  // Stand-in classifier: weighted feature sum modulo 3.
  function automatic logic golden(input int qv [FEAT_N]);
    int s;
    s = 0;
    for (int k = 0; k < FEAT_N; k++) s += qv[k] * (k + 1);
    return (s % 3) == 1;
  endfunction

  function automatic logic core_on_vec(input logic [VW-1:0] v);
    int qv [FEAT_N];
    for (int k = 0; k < FEAT_N; k++) qv[k] = int'(v[2*k +: 2]);
    return golden(qv);
  endfunction

  always_comb cls_bit = core_on_vec(cls_vec);

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < FEAT_N; k++) v = v | (VW'(model_q[k]) << (2*k));
    return v;
  endfunction

  function automatic int rand_sample();
    int bl [8];
    bl = '{0, 63, 64, 127, 128, 191, 192, 255};
    if ($urandom_range(0, 3) == 0) return bl[$urandom_range(0, 7)];
    return int'($urandom_range(0, 255));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check("reset_outputs", {s_ready, m_valid, m_class, m_err}, 4'b0000);
    check("reset_vec", cls_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", {s_ready, m_valid}, 2'b10);
    for (int k = 0; k < FEAT_N; k++) model_q[k] = 0;
  endtask

  task automatic send_beat(input int val, input bit last);
    int budget;
    budget  = 20;
    s_valid = 1'b1;
    s_data  = 8'(val);
    s_last  = last;
    while (s_ready !== 1'b1 && budget > 0) begin
      early_valid |= m_valid;
      m_ready = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    if (s_ready !== 1'b1) check("beat_accept_timeout", {31'd0, s_ready}, 32'd1);
    early_valid |= m_valid;
    m_ready = 1'($urandom_range(0, 1));
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_frame(input int d [$], input bit gaps);
    early_valid = 1'b0;
    for (int i = 0; i < d.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          early_valid |= m_valid;
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      send_beat(d[i], i == d.size() - 1);
      if (i < FEAT_N) model_q[i] = quant(d[i]);
    end
    check("no_early_valid", {31'd0, early_valid}, 32'd0);
  endtask

  task automatic expect_result(input int len, input int stall);
    logic          exp_c;
    logic          exp_e;
    logic [VW-1:0] exp_v;
    exp_e = (len != FEAT_N);
    exp_c = exp_e ? 1'b0 : golden(model_q);
    exp_v = model_vec();
    if (!exp_e) begin
      check("eval_cycle", {m_valid, s_ready}, 2'b00);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("result_valid", {m_valid, s_ready}, 2'b10);
    check("result_fields", {m_class, m_err, cls_vec}, {exp_c, exp_e, exp_v});
    for (int i = 0; i < stall; i++) begin
      m_ready = 1'b0;
      tick();
      check("hold_stable", {m_valid, s_ready, m_class, m_err, cls_vec},
            {1'b1, 1'b0, exp_c, exp_e, exp_v});
    end
    m_ready = 1'b1;
    if (m_valid === 1'b1) results++;
    tick();
    m_ready = 1'b0;
    check("after_release", {m_valid, s_ready}, 2'b01);
  endtask

  initial begin
    int d [$];
    int tp [7];
    int len;
    int r;

    apply_reset();

    // Test-plan frame with 5 cycles of backpressure.
    tp = '{0, 64, 127, 128, 191, 192, 255};
    d.delete();
    foreach (tp[i]) d.push_back(tp[i]);
    send_frame(d, 1'b0);
    check("tp_vec", cls_vec, 14'b11_11_10_10_01_01_00);
    expect_result(7, 5);
    frames++;

    // Short frame followed by a good frame.
    d.delete();
    for (int i = 0; i < 3; i++) d.push_back(rand_sample());
    send_frame(d, 1'b0);
    expect_result(3, 0);
    frames++;
    d.delete();
    for (int i = 0; i < 7; i++) d.push_back(rand_sample());
    send_frame(d, 1'b0);
    expect_result(7, 0);
    frames++;

    // Long frame of 10 beats.
    d.delete();
    for (int i = 0; i < 10; i++) d.push_back(rand_sample());
    send_frame(d, 1'b0);
    expect_result(10, 1);
    frames++;

    // Reset while the 4th sample is presented, then a fresh good frame.
    for (int i = 0; i < 3; i++) send_beat(rand_sample(), 1'b0);
    s_valid = 1'b1;
    s_data  = 8'd200;
    apply_reset();
    d.delete();
    for (int i = 0; i < 7; i++) d.push_back(rand_sample());
    send_frame(d, 1'b0);
    expect_result(7, 0);
    frames++;

    // Reset while a result is pending: it must vanish.
    d.delete();
    for (int i = 0; i < 2; i++) d.push_back(rand_sample());
    send_frame(d, 1'b0);
    check("pending_before_reset", {31'd0, m_valid}, 32'd1);
    apply_reset();

    // Randomized frames, gaps and backpressure.
    for (int f = 0; f < 1000; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       len = 7;
      else if (r == 6) len = int'($urandom_range(1, 6));
      else             len = int'($urandom_range(8, 10));
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(rand_sample());
      send_frame(d, 1'b1);
      expect_result(len, int'($urandom_range(0, 3)));
      frames++;
    end

    check("frame_count", results, frames);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
